// File: rtl/data_mem_responder_if.sv
// Load/store port between the core and its data memory: a valid/ready request
// channel and a valid/ready response channel.
interface data_mem_responder_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) ();
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;
    logic              resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/data_mem_responder.sv
// Single-outstanding data memory responder: clears the array after reset,
// then serves one read/write at a time after a fixed number of wait states.
module data_mem_responder #(
    parameter int ADDR_W      = 8,
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    data_mem_responder_if.slave bus,
    output logic                init_busy
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_WAIT, S_RESP} state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  init_ptr_q, init_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic              init_busy_q, init_busy_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic              mem_we;
    logic [IDX_W-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              acc_en;
    logic              acc_we;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    logic              acc_in_range;
    logic [IDX_W-1:0]  acc_idx;

    always_comb begin
        state_d      = state_q;
        init_ptr_d   = init_ptr_q;
        cnt_d        = cnt_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        req_ready_d  = req_ready_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        init_busy_d  = init_busy_q;
        mem_we       = 1'b0;
        mem_waddr    = init_ptr_q;
        mem_wdata    = '0;
        acc_en       = 1'b0;
        acc_we       = we_q;
        acc_addr     = addr_q;
        acc_wdata    = wdata_q;

        case (state_q)
            S_INIT: begin
                mem_we     = 1'b1;
                init_ptr_d = init_ptr_q + 1'b1;
                if (init_ptr_q == IDX_W'(DEPTH - 1)) begin
                    state_d     = S_IDLE;
                    init_ptr_d  = '0;
                    init_busy_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    we_d        = bus.req_we;
                    addr_d      = bus.req_addr;
                    wdata_d     = bus.req_wdata;
                    req_ready_d = 1'b0;
                    // Zero wait states: access straight from the bus on the handshake edge.
                    if (WAIT_CYCLES == 0) begin
                        acc_en    = 1'b1;
                        acc_we    = bus.req_we;
                        acc_addr  = bus.req_addr;
                        acc_wdata = bus.req_wdata;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = CNT_W'(WAIT_CYCLES);
                    end
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_W'(1)) begin
                    acc_en = 1'b1;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_RESP: begin
                if (bus.resp_ready) begin
                    state_d      = S_IDLE;
                    resp_valid_d = 1'b0;
                    req_ready_d  = 1'b1;
                end
            end
            default: state_d = S_INIT;
        endcase

        acc_in_range = (32'(acc_addr) < 32'(DEPTH));
        acc_idx      = acc_addr[IDX_W-1:0];

        if (acc_en) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            resp_rdata_d = '0;
            resp_err_d   = 1'b0;
            if (!acc_in_range) begin
                resp_err_d = 1'b1;
            end else if (acc_we) begin
                mem_we    = 1'b1;
                mem_waddr = acc_idx;
                mem_wdata = acc_wdata;
            end else begin
                resp_rdata_d = mem[acc_idx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_INIT;
            init_ptr_q   <= '0;
            cnt_q        <= '0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            init_busy_q  <= 1'b1;
        end else begin
            state_q      <= state_d;
            init_ptr_q   <= init_ptr_d;
            cnt_q        <= cnt_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            init_busy_q  <= init_busy_d;
        end
    end

    // Storage has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = resp_rdata_q;
    assign bus.resp_err   = resp_err_q;
    assign init_busy      = init_busy_q;
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level model compared every cycle,
// directed scenarios with literal expectations, and a zero-wait instance.
module tb_data_mem_responder;
    localparam int DEPTH  = 16;
    localparam int WAIT_A = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_b = 1'b0;
    always #5 clk = ~clk;

    data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_a ();
    data_mem_responder_if #(.ADDR_W(8), .DATA_W(8)) bus_b ();
    logic init_busy_a, init_busy_b;

    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(WAIT_A)) dut_a (
        .clk(clk), .rst_n(rst_n), .bus(bus_a), .init_busy(init_busy_a)
    );
    data_mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .rst_n(rst_b), .bus(bus_b), .init_busy(init_busy_b)
    );

    assign bus_b.req_valid  = 1'b1;
    assign bus_b.resp_ready = 1'b1;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Transaction-level model of instance A: cycle count since reset release,
    // one outstanding request, response due WAIT_A+1 cycles after acceptance.
    int         cyc;
    bit         outstanding;
    int         due;
    logic [7:0] pend_rdata, shown_rdata;
    logic       pend_err, shown_err;
    logic [7:0] mem_m [DEPTH];
    logic       m_valid;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc         <= 0;
            outstanding <= 1'b0;
            due         <= 0;
            pend_rdata  <= 8'h00;
            pend_err    <= 1'b0;
            shown_rdata <= 8'h00;
            shown_err   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem_m[i] <= 8'h00;
        end else begin
            cyc <= cyc + 1;
            if (cyc >= DEPTH && !outstanding && bus_a.req_valid) begin
                outstanding <= 1'b1;
                due         <= cyc + WAIT_A + 1;
                if (int'(bus_a.req_addr) >= DEPTH) begin
                    pend_rdata <= 8'h00;
                    pend_err   <= 1'b1;
                end else if (bus_a.req_we) begin
                    mem_m[bus_a.req_addr[3:0]] <= bus_a.req_wdata;
                    pend_rdata <= 8'h00;
                    pend_err   <= 1'b0;
                end else begin
                    pend_rdata <= mem_m[bus_a.req_addr[3:0]];
                    pend_err   <= 1'b0;
                end
            end
            if (outstanding && cyc >= due && bus_a.resp_ready) begin
                outstanding <= 1'b0;
                shown_rdata <= pend_rdata;
                shown_err   <= pend_err;
            end
        end
    end

    always @(negedge clk) begin
        m_valid = outstanding && (cyc >= due);
        check("cmp_init_busy",  32'(init_busy_a),      32'(cyc < DEPTH));
        check("cmp_req_ready",  32'(bus_a.req_ready),  32'(cyc >= DEPTH && !outstanding));
        check("cmp_resp_valid", 32'(bus_a.resp_valid), 32'(m_valid));
        check("cmp_resp_rdata", 32'(bus_a.resp_rdata), 32'(m_valid ? pend_rdata : shown_rdata));
        check("cmp_resp_err",   32'(bus_a.resp_err),   32'(m_valid ? pend_err : shown_err));
    end

    task automatic wait_ready_a(output int n);
        n = 0;
        while (bus_a.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("a_ready");
    endtask

    task automatic wait_resp_a(output int lat);
        lat = 1;
        while (bus_a.resp_valid !== 1'b1 && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (lat >= 100) timeout("a_resp");
    endtask

    // Called on a negedge; returns on the negedge after the response handshake.
    task automatic xact(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                        output logic [7:0] rdata, output logic err, output int lat);
        int n;
        bus_a.req_we     = we;
        bus_a.req_addr   = addr;
        bus_a.req_wdata  = wdata;
        bus_a.req_valid  = 1'b1;
        bus_a.resp_ready = 1'b1;
        wait_ready_a(n);
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        wait_resp_a(lat);
        rdata = bus_a.resp_rdata;
        err   = bus_a.resp_err;
        @(negedge clk);
    endtask

    logic [7:0] rd;
    logic       er;
    int         lat;
    int         n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_a.req_valid  = 1'b0;
        bus_a.req_we     = 1'b0;
        bus_a.req_addr   = 8'h00;
        bus_a.req_wdata  = 8'h00;
        bus_a.resp_ready = 1'b0;
        bus_b.req_we     = 1'b1;
        bus_b.req_addr   = 8'h01;
        bus_b.req_wdata  = 8'h11;

        repeat (3) @(negedge clk);
        check("rst_init_busy",  32'(init_busy_a),      32'(1));
        check("rst_req_ready",  32'(bus_a.req_ready),  32'(0));
        check("rst_resp_valid", 32'(bus_a.resp_valid), 32'(0));
        rst_n = 1'b1;
        wait_ready_a(n);
        check("init_cycles", 32'(n), 32'(16));

        xact(1'b0, 8'd5, 8'h00, rd, er, lat);
        check("rd5_rdata", 32'(rd), 32'h00);
        check("rd5_err",   32'(er), 32'(0));

        xact(1'b1, 8'd3, 8'h2A, rd, er, lat);
        check("wr3_latency", 32'(lat), 32'(3));
        check("wr3_rdata",   32'(rd),  32'h00);
        check("wr3_err",     32'(er),  32'(0));

        xact(1'b0, 8'd3, 8'h00, rd, er, lat);
        check("rd3_rdata", 32'(rd), 32'h2A);
        check("rd3_err",   32'(er), 32'(0));

        xact(1'b0, 8'd20, 8'h00, rd, er, lat);
        check("rd20_rdata", 32'(rd), 32'h00);
        check("rd20_err",   32'(er), 32'(1));

        xact(1'b1, 8'd16, 8'h77, rd, er, lat);
        check("wr16_err", 32'(er), 32'(1));

        xact(1'b0, 8'd0, 8'h00, rd, er, lat);
        check("rd0_rdata", 32'(rd), 32'h00);
        xact(1'b0, 8'd15, 8'h00, rd, er, lat);
        check("rd15_rdata", 32'(rd), 32'h00);

        // Backpressure with a second request waiting behind the response.
        bus_a.resp_ready = 1'b0;
        bus_a.req_we     = 1'b0;
        bus_a.req_addr   = 8'd3;
        bus_a.req_valid  = 1'b1;
        wait_ready_a(n);
        @(negedge clk);
        bus_a.req_we    = 1'b1;
        bus_a.req_addr  = 8'd9;
        bus_a.req_wdata = 8'h66;
        wait_resp_a(lat);
        for (int i = 0; i < 5; i++) begin
            check("bp_resp_valid", 32'(bus_a.resp_valid), 32'(1));
            check("bp_rdata",      32'(bus_a.resp_rdata), 32'h2A);
            check("bp_req_ready",  32'(bus_a.req_ready),  32'(0));
            @(negedge clk);
        end
        bus_a.resp_ready = 1'b1;
        check("bp_hs_req_ready", 32'(bus_a.req_ready), 32'(0));
        @(negedge clk);
        check("bp_after_valid", 32'(bus_a.resp_valid), 32'(0));
        check("bp_after_ready", 32'(bus_a.req_ready),  32'(1));
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        check("bp_second_taken", 32'(bus_a.req_ready), 32'(0));
        wait_resp_a(lat);
        check("bp_second_err", 32'(bus_a.resp_err), 32'(0));
        @(negedge clk);
        xact(1'b0, 8'd9, 8'h00, rd, er, lat);
        check("rd9_rdata", 32'(rd), 32'h66);

        // Reset in the middle of a write's wait states.
        bus_a.req_we    = 1'b1;
        bus_a.req_addr  = 8'd7;
        bus_a.req_wdata = 8'h55;
        bus_a.req_valid = 1'b1;
        wait_ready_a(n);
        @(negedge clk);
        bus_a.req_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_resp_valid", 32'(bus_a.resp_valid), 32'(0));
        check("mid_rst_req_ready",  32'(bus_a.req_ready),  32'(0));
        check("mid_rst_rdata",      32'(bus_a.resp_rdata), 32'h00);
        check("mid_rst_err",        32'(bus_a.resp_err),   32'(0));
        check("mid_rst_init_busy",  32'(init_busy_a),      32'(1));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        wait_ready_a(n);
        check("reinit_cycles", 32'(n), 32'(16));
        xact(1'b0, 8'd7, 8'h00, rd, er, lat);
        check("rd7_after_rst", 32'(rd), 32'h00);

        // Zero-wait instance: request and response channels held valid/ready.
        rst_b = 1'b1;
        n = 0;
        while (bus_b.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) timeout("b_ready");
        check("b_init_cycles", 32'(n), 32'(16));
        for (int i = 0; i < 6; i++) begin
            check("b_req_ready", 32'(bus_b.req_ready), 32'(1));
            @(negedge clk);
            check("b_resp_valid", 32'(bus_b.resp_valid), 32'(1));
            check("b_busy_ready", 32'(bus_b.req_ready),  32'(0));
            check("b_rdata",      32'(bus_b.resp_rdata), (i % 2 == 1) ? 32'h11 : 32'h00);
            check("b_err",        32'(bus_b.resp_err),   32'(0));
            bus_b.req_we = (i % 2 == 1);
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the multi-cycle core's load/store port: one-word-wide data memory slave behind a valid/ready request channel and a valid/ready response channel.
- Accepts one read or write at a time, inserts a fixed number of wait states, then returns read data or a write acknowledge plus an error flag.
- After reset, a sequential sweep clears every word before any request is accepted.
- Sits between the core's execute stage and data storage, replacing the core-local data array.

Parameters:
- ADDR_W, 8, request address width.
- DATA_W, 8, data word width; matches the core's register width.
- DEPTH, 16, number of words; valid addresses are 0..DEPTH-1.
- WAIT_CYCLES, 2, wait states between request acceptance and the memory access; 0 is legal.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  DATA_W  read data; 0 for writes and errors.
- resp_err  out  1  address was out of range.
- init_busy  out  1  clear sweep in progress.

Behaviour:
- Reset is asynchronous on rst_n low. Immediately: state=INIT, init_ptr=0, req_ready=0, resp_valid=0, resp_rdata=0, resp_err=0, init_busy=1. Memory is not reset directly; the INIT sweep clears it.
- States are INIT, IDLE, WAIT, RESP.
- INIT:
  - Each cycle writes 0 to mem[init_ptr] and increments init_ptr.
  - After the write of DEPTH-1, the next state is IDLE.
  - init_busy is high for exactly DEPTH cycles after reset release.
  - req_valid is ignored; nothing is captured.
- IDLE:
  - req_ready=1; req_ready is high only in IDLE.
  - Handshake is req_valid && req_ready at a rising edge. On handshake, latch req_we, req_addr and req_wdata.
  - If WAIT_CYCLES>0, go to WAIT with the counter set to WAIT_CYCLES.
  - If WAIT_CYCLES=0, perform the access on the same edge and go to RESP.
- WAIT:
  - The counter decrements each cycle.
  - On the cycle the counter reaches 1, perform the access at that edge and go to RESP.
- Access rules (latched address compared at full ADDR_W; no aliasing or wrap):
  - addr >= DEPTH: no memory change, resp_err=1, resp_rdata=0.
  - Read in range: resp_rdata=mem[addr], resp_err=0.
  - Write in range: mem[addr]=wdata, resp_rdata=0, resp_err=0.
- Latency: handshake edge at cycle N gives resp_valid high from cycle N+WAIT_CYCLES+1.
- RESP:
  - resp_valid=1. resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake, go to IDLE. resp_valid is low the following cycle, and rdata/err hold their last values.
  - resp_ready is ignored outside RESP.
- Only one transaction is outstanding. A new request cannot be accepted in the response-handshake cycle; the earliest next acceptance is the cycle after.
- A read immediately following a write to the same address returns the new data, because the write completes before its response.
- Reset mid-operation: a pending request or response is dropped with no response issued, and the memory is re-cleared by a new INIT sweep.
- The memory array uses synchronous write and registered read into resp_rdata.

Test Plan:
- Reset release, DEPTH=16, WAIT_CYCLES=2 -> init_busy high exactly 16 cycles, req_ready rises on cycle 16; then read addr 5 -> resp_rdata=0x00, resp_err=0.
- Write 0x2A to addr 3 with handshake at cycle N -> resp_valid at N+3, rdata=0x00, err=0; then read addr 3 -> rdata=0x2A, err=0.
- Out-of-range cases:
  - Read addr 20 -> err=1, rdata=0.
  - Write 0x77 to addr 16 -> err=1.
  - Subsequent reads of addrs 0 and 15 -> 0x00 (no aliasing).
- Backpressure: hold resp_ready low 5 cycles while req_valid stays high with a second request -> resp_valid and rdata stable, req_ready low throughout; the second request is accepted only the cycle after the response handshake.
- Write 0x55 to addr 7, assert rst_n low during WAIT -> all outputs 0 immediately, no response; after the 16-cycle re-init, read addr 7 -> 0x00.
- WAIT_CYCLES=0 instance, req_valid and resp_ready tied high, alternating write 0x11 to addr 1 then read addr 1 -> one transaction every 2 cycles, read returns 0x11.
